// File: rtl/yc_noc_route_demux_if.sv
// Flit-in / per-output-out bundle between a router input stage and its output arbiters.
// The slave view belongs to the demux; the master view drives flits and returns credits.
interface yc_noc_route_demux_if #(
    parameter int N = 5,
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_flit;
    logic         in_head;
    logic         in_tail;
    logic [N-1:0] out_valid;
    logic [W-1:0] out_flit;
    logic         out_head;
    logic         out_tail;
    logic [N-1:0] credit_ret;
    logic         drop_pulse;
    logic         cred_err;

    modport slave (
        input  in_valid, in_flit, in_head, in_tail, credit_ret,
        output in_ready, out_valid, out_flit, out_head, out_tail, drop_pulse, cred_err
    );

    modport master (
        output in_valid, in_flit, in_head, in_tail, credit_ret,
        input  in_ready, out_valid, out_flit, out_head, out_tail, drop_pulse, cred_err
    );
endinterface

// File: rtl/yc_noc_route_demux.sv
// Wormhole route demux: steers each packet to the output named by its head flit, drops bad dests.
// Latency: 1 cycle from input acceptance to presentation (when the target port holds a credit).
// Backpressure: single-entry buffer; in_ready drops only while the buffered flit is stalled on credits.
module yc_noc_route_demux #(
    parameter int N       = 5,
    parameter int W       = 32,
    parameter int CREDITS = 4
) (
    input logic               clk,
    input logic               rst_n,
    yc_noc_route_demux_if.slave bus
);
    localparam int             DW        = (N > 1) ? $clog2(N) : 1;
    localparam int             CW        = $clog2(CREDITS + 1);
    localparam logic [DW:0]    NUM_PORTS = (DW + 1)'(N);
    localparam logic [CW-1:0]  CMAX      = CW'(CREDITS);
    localparam logic [CW-1:0]  CONE      = CW'(1);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t        state;
    logic [DW-1:0] sel;

    logic          full;
    logic [W-1:0]  buf_flit;
    logic          buf_head;
    logic          buf_tail;

    logic [CW-1:0] cred_cnt [N];

    logic [DW-1:0] dest;
    logic [DW-1:0] port;
    logic          in_idle;
    logic          dest_ok;
    logic          head_ok;
    logic          head_bad;
    logic          fwd;
    logic          send;
    logic          discard;
    logic          buf_leave;
    logic          accept;
    logic [N-1:0]  cred_nz;
    logic [N-1:0]  at_max;
    logic [N-1:0]  dec;

    assign dest      = buf_flit[DW-1:0];
    assign dest_ok   = {1'b0, dest} < NUM_PORTS;
    assign in_idle   = (state == IDLE);
    assign head_ok   = full && in_idle && buf_head && dest_ok;
    assign head_bad  = full && in_idle && buf_head && !dest_ok;
    // A head in IDLE is steered by its own dest field before sel has been latched.
    assign port      = in_idle ? dest : sel;
    assign fwd       = head_ok || (full && state == ROUTE);
    assign send      = fwd && cred_nz[port];
    assign discard   = full && ((in_idle && !(buf_head && dest_ok)) || state == DROP);
    assign buf_leave = send || discard;
    assign accept    = bus.in_valid && bus.in_ready;

    always_comb begin
        cred_nz = '0;
        at_max  = '0;
        dec     = '0;
        for (int k = 0; k < N; k++) begin
            cred_nz[k] = (cred_cnt[k] != '0);
            at_max[k]  = (cred_cnt[k] == CMAX);
            dec[k]     = send && (port == DW'(k));
        end
    end

    assign bus.in_ready   = !full || buf_leave;
    assign bus.out_valid  = dec;
    assign bus.out_flit   = full ? buf_flit : '0;
    assign bus.out_head   = full && buf_head;
    assign bus.out_tail   = full && buf_tail;
    assign bus.drop_pulse = head_bad;
    // A return on a port that is also sending this cycle is absorbed, never an overflow.
    assign bus.cred_err   = |(bus.credit_ret & ~dec & at_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            buf_flit <= '0;
            buf_head <= 1'b0;
            buf_tail <= 1'b0;
        end else if (accept) begin
            full     <= 1'b1;
            buf_flit <= bus.in_flit;
            buf_head <= bus.in_head;
            buf_tail <= bus.in_tail;
        end else if (buf_leave) begin
            full     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) cred_cnt[k] <= CMAX;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (bus.credit_ret[k] && !dec[k]) begin
                    if (!at_max[k]) cred_cnt[k] <= cred_cnt[k] + CONE;
                end else if (dec[k] && !bus.credit_ret[k]) begin
                    cred_cnt[k] <= cred_cnt[k] - CONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (head_ok) begin
                        sel <= dest;
                        if (!(send && buf_tail)) state <= ROUTE;
                    end else if (head_bad && !buf_tail) begin
                        state <= DROP;
                    end
                end
                ROUTE: if (send && buf_tail) state <= IDLE;
                DROP:  if (full && buf_tail) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
